// File: rtl/data_memory_responder.sv
// Multi-cycle word-addressed data memory answering the CPU READ/WRITE/BUSYWAIT handshake.
// Optional macro DMEM_PROTOCOL_CHECK_EN adds a sticky ERROR output for handshake violations.
module data_memory_responder #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 5
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              READ,
  input  logic              WRITE,
  input  logic [ADDR_W-1:0] ADDRESS,
  input  logic [DATA_W-1:0] WRITEDATA,
  output logic [DATA_W-1:0] READDATA,
`ifdef DMEM_PROTOCOL_CHECK_EN
  output logic              ERROR,
`endif
  output logic              BUSYWAIT
);

  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(LATENCY);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state, next_state;

  logic [CNT_W-1:0]  counter;
  logic [MEM_AW-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              wr_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic req;
  logic capture;
  logic last;

  assign req     = READ | WRITE;
  assign capture = (state == IDLE) && req;
  assign last    = (state == ACCESS) && (counter == CNT_W'(1));

  // state register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= next_state;
  end

  // next state and stall output; stall is masked while in reset
  always_comb begin
    next_state = state;
    BUSYWAIT   = 1'b0;
    unique case (state)
      IDLE: begin
        BUSYWAIT = req & RESET;
        if (req) next_state = ACCESS;
      end
      ACCESS: begin
        BUSYWAIT = RESET;
        if (last) next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // operand capture, latency counter and registered load data
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      counter  <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      wr_q     <= 1'b0;
      READDATA <= '0;
    end else if (capture) begin
      counter <= CNT_W'(LATENCY - 1);
      addr_q  <= ADDRESS[MEM_AW-1:0];
      data_q  <= WRITEDATA;
      wr_q    <= WRITE;
    end else if (state == ACCESS) begin
      counter <= counter - CNT_W'(1);
      if (last && !wr_q) READDATA <= mem[addr_q];
    end
  end

  // storage array, deliberately not reset
  always_ff @(posedge CLK) begin
    if (last && wr_q) mem[addr_q] <= data_q;
  end

`ifdef DMEM_PROTOCOL_CHECK_EN
  logic [ADDR_W-1:0] chk_addr;
  logic [DATA_W-1:0] chk_data;
  logic              chk_rd;
  logic              chk_wr;
  logic              bad_idle;
  logic              bad_access;

  assign bad_idle   = (state == IDLE) && READ && WRITE;
  assign bad_access = (state == ACCESS) &&
                      ((chk_rd && !READ) ||
                       (chk_wr && !WRITE) ||
                       (ADDRESS != chk_addr) ||
                       (WRITEDATA != chk_data));

  // sticky handshake violation flag
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ERROR    <= 1'b0;
      chk_addr <= '0;
      chk_data <= '0;
      chk_rd   <= 1'b0;
      chk_wr   <= 1'b0;
    end else begin
      if (bad_idle || bad_access) ERROR <= 1'b1;
      if (capture) begin
        chk_addr <= ADDRESS;
        chk_data <= WRITEDATA;
        chk_rd   <= READ;
        chk_wr   <= WRITE;
      end
    end
  end
`endif

endmodule
